// File: rtl/alu_share_pkg.sv
// +------------------------------------------------------------------+
// | alu_share_pkg: opcodes and FSM states for the shared ALU arbiter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package alu_share_pkg;

  localparam logic [3:0] OP_ADD4   = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_NOT    = 4'd5;
  localparam logic [3:0] OP_SELADD = 4'd6;
  localparam logic [3:0] OP_ADD4R  = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// +------------------------------------------------------------------+
// | alu_core: combinational ALU evaluated on the captured operands   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module alu_core
  import alu_share_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [3:0]   opcode,
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD4, OP_ADD4R: result = a + b + c + d;
      OP_SUB:            result = a - b;
      OP_AND:            result = a & b;
      OP_OR:             result = a | b;
      OP_XOR:            result = a ^ b;
      OP_NOT:            result = ~a;
      OP_SELADD:         result = sel ? (a + c) : (b + d);
      default:           result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// +------------------------------------------------------------------+
// | alu_share_arbiter: round-robin sharing of one ALU by two clients |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [7:0]     req_opcode,
  input  logic [1:0]     req_sel,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [2*W-1:0] req_c,
  input  logic [2*W-1:0] req_d,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_zero,
  output logic           busy
);

  state_t state, state_nxt;
  logic   rr_ptr;
  logic   owner;
  logic   grant;
  logic   accept;
  logic   rsp_done;

  logic [3:0]   op_q;
  logic         sel_q;
  logic [W-1:0] a_q, b_q, c_q, d_q;
  logic [W-1:0] alu_result;
  logic         alu_zero;

  // Preferred requester wins if it is asking, otherwise the other one.
  always_comb begin
    grant     = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid[grant]) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_nxt        = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      op_q       <= '0;
      sel_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= grant;
        op_q  <= grant ? req_opcode[7:4]   : req_opcode[3:0];
        sel_q <= grant ? req_sel[1]        : req_sel[0];
        a_q   <= grant ? req_a[2*W-1:W]    : req_a[W-1:0];
        b_q   <= grant ? req_b[2*W-1:W]    : req_b[W-1:0];
        c_q   <= grant ? req_c[2*W-1:W]    : req_c[W-1:0];
        d_q   <= grant ? req_d[2*W-1:W]    : req_d[W-1:0];
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
      // Finished owner yields priority to the other requester.
      if (rsp_done) begin
        rr_ptr <= ~owner;
      end
    end
  end

  alu_core #(
    .W (W)
  ) u_alu_core (
    .opcode (op_q),
    .sel    (sel_q),
    .a      (a_q),
    .b      (b_q),
    .c      (c_q),
    .d      (d_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, corner
// sequences, and randomized traffic against a transaction-level model.
`default_nettype none

module tb_alu_share_arbiter;

  localparam int W  = 8;
  localparam int FW = 5 + 4 * W;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid, req_ready, req_sel, rsp_valid, rsp_ready;
  logic [7:0]     req_opcode;
  logic [2*W-1:0] req_a, req_b, req_c, req_d;
  logic [W-1:0]   rsp_result;
  logic           rsp_zero, busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_sel    (req_sel),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .req_d      (req_d),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  typedef struct {
    int    r;
    int    op;
    int    sel;
    int    a, b, c, d;
    int    exp_res;
    int    exp_zero;
    string name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: plain integer arithmetic reduced modulo 2**W.
  function automatic logic [W-1:0] ref_alu(input int op, input int s, input int a,
                                           input int b, input int c, input int d);
    int r;
    int m;
    m = 1 << W;
    case (op)
      0, 7:    r = a + b + c + d;
      1:       r = a - b;
      2:       r = a & b;
      3:       r = a | b;
      4:       r = a ^ b;
      5:       r = (m - 1) - a;
      6:       r = (s != 0) ? a + c : b + d;
      default: r = 0;
    endcase
    r = ((r % m) + m) % m;
    return W'(r);
  endfunction

  task automatic set_req(input int r, input int op, input int s, input int a,
                         input int b, input int c, input int d);
    if (r == 0) begin
      req_opcode[3:0] = 4'(op);
      req_sel[0]      = 1'(s);
      req_a[W-1:0]    = W'(a);
      req_b[W-1:0]    = W'(b);
      req_c[W-1:0]    = W'(c);
      req_d[W-1:0]    = W'(d);
    end else begin
      req_opcode[7:4]   = 4'(op);
      req_sel[1]        = 1'(s);
      req_a[2*W-1:W]    = W'(a);
      req_b[2*W-1:W]    = W'(b);
      req_c[2*W-1:W]    = W'(c);
      req_d[2*W-1:W]    = W'(d);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issue one request alone, checking grant, latency, routing and result.
  task automatic run_op(input vec_t v);
    int n;
    set_req(v.r, v.op, v.sel, v.a, v.b, v.c, v.d);
    req_valid = 2'b01 << v.r;
    rsp_ready = 2'b00;
    #1;
    n = 0;
    while (req_ready[v.r] !== 1'b1 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check({v.name, "_ready"}, req_ready, 2'b01 << v.r);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1;
    check({v.name, "_exec"}, {req_ready, rsp_valid, busy}, {2'b00, 2'b00, 1'b1});
    @(posedge clk); #2;
    check({v.name, "_rsp"}, rsp_valid, 2'b01 << v.r);
    check({v.name, "_res"}, {rsp_zero, rsp_result}, {1'(v.exp_zero), W'(v.exp_res)});
    rsp_ready = 2'b01 << v.r;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    #1;
    check({v.name, "_done"}, {rsp_valid, busy}, 3'b000);
  endtask

  // Request fields must hold while valid is up and not yet accepted.
  logic [1:0]    pv, pr;
  logic [FW-1:0] pf0, pf1;

  function automatic logic [FW-1:0] fields(input int i);
    if (i == 0)
      return {req_opcode[3:0], req_sel[0], req_a[W-1:0], req_b[W-1:0], req_c[W-1:0], req_d[W-1:0]};
    return {req_opcode[7:4], req_sel[1], req_a[2*W-1:W], req_b[2*W-1:W], req_c[2*W-1:W], req_d[2*W-1:W]};
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      if (pv[0] === 1'b1 && pr[0] === 1'b0 && req_valid[0] === 1'b1)
        assert (fields(0) == pf0) else begin
          mismatched++;
          $display("FAIL protocol r0: fields 0x%0h changed from 0x%0h", fields(0), pf0);
        end
      if (pv[1] === 1'b1 && pr[1] === 1'b0 && req_valid[1] === 1'b1)
        assert (fields(1) == pf1) else begin
          mismatched++;
          $display("FAIL protocol r1: fields 0x%0h changed from 0x%0h", fields(1), pf1);
        end
    end
    pv  <= (rst === 1'b0) ? req_valid : 2'b00;
    pr  <= req_ready;
    pf0 <= fields(0);
    pf1 <= fields(1);
  end

  vec_t tbl[11];

  initial begin
    int acc_grant[8];
    int acc_cyc[8];
    int n_acc;
    int p_op[2], p_sel[2], p_a[2], p_b[2], p_c[2], p_d[2];
    bit pend[2];
    bit m_busy, m_owner, m_pref;
    int m_age;
    logic [W-1:0] m_res, last_res;
    logic last_zero;
    logic [1:0] exp_ready;

    tbl[0]  = '{0, 0, 0, 'h40, 'h40, 'h40, 'h41, 'h01, 0, "add4_wrap"};
    tbl[1]  = '{1, 1, 0, 'h33, 'h33, 'h00, 'h00, 'h00, 1, "sub_zero"};
    tbl[2]  = '{0, 6, 1, 'h10, 'h77, 'h05, 'h88, 'h15, 0, "seladd_s1"};
    tbl[3]  = '{0, 6, 0, 'h99, 'hFF, 'h11, 'h02, 'h01, 0, "seladd_s0"};
    tbl[4]  = '{0, 9, 1, 'h12, 'h34, 'h56, 'h78, 'h00, 1, "op9_zero"};
    tbl[5]  = '{1, 7, 0, 'h80, 'h80, 'h01, 'h02, 'h03, 0, "add4r"};
    tbl[6]  = '{1, 5, 0, 'h5A, 'h00, 'h00, 'h00, 'hA5, 0, "not"};
    tbl[7]  = '{0, 2, 0, 'hF0, 'h3C, 'h00, 'h00, 'h30, 0, "and"};
    tbl[8]  = '{1, 3, 0, 'hF0, 'h0C, 'h00, 'h00, 'hFC, 0, "or"};
    tbl[9]  = '{0, 4, 0, 'hFF, 'h0F, 'h00, 'h00, 'hF0, 0, "xor"};
    tbl[10] = '{1, 1, 0, 'h01, 'h02, 'h00, 'h00, 'hFF, 0, "sub_wrap"};

    req_opcode = '0; req_sel = '0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    rst = 1'b1;
    #3;
    check("reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_zero, busy}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_op(tbl[i]);

    // Reset during EXEC: operation is dropped and result is cleared.
    set_req(0, 0, 0, 1, 2, 3, 4);
    req_valid = 2'b01;
    #1;
    check("rstmid_accept", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("rstmid_exec", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rstmid_async", {busy, rsp_zero, rsp_result}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rstmid_no_rsp", {rsp_valid, busy}, 3'b000);
      @(posedge clk); #1;
    end

    // Both requesters always valid: grants alternate, one accept per 3 cycles.
    do_reset();
    set_req(0, 0, 0, 1, 2, 3, 4);
    set_req(1, 1, 0, 9, 4, 0, 0);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    n_acc = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      #1;
      if (req_ready != 2'b00 && n_acc < 8) begin
        acc_grant[n_acc] = int'(req_ready[1]);
        acc_cyc[n_acc]   = cyc;
        n_acc++;
      end
      @(posedge clk); #1;
    end
    check("fair_count", 64'(n_acc >= 4), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check("fair_grant", 64'(acc_grant[k]), 64'(k % 2));
      if (k > 0) check("fair_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd3);
    end

    // Response backpressure with a pending r1 request and r1's ready ignored.
    do_reset();
    set_req(0, 4, 0, 'hAA, 'h55, 0, 0);
    req_valid = 2'b01;
    #1;
    check("bp_accept_r0", req_ready, 2'b01);
    @(posedge clk); #1;
    set_req(1, 0, 0, 1, 1, 1, 1);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    #1;
    check("bp_exec_noready", req_ready, 2'b00);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_hold", {req_ready, rsp_valid, rsp_zero, rsp_result}, {2'b00, 2'b01, 1'b0, 8'hFF});
      @(posedge clk); #1;
    end
    rsp_ready = 2'b01;
    #1;
    check("bp_release", rsp_valid, 2'b01);
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    set_req(0, 2, 0, 'h0F, 'h0F, 0, 0);
    req_valid = 2'b11;
    #1;
    check("bp_next_r1", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b01;
    @(posedge clk); #2;
    check("bp_r1_rsp", {rsp_valid, rsp_result}, {2'b10, 8'h04});
    rsp_ready = 2'b10;
    @(posedge clk); #2;
    check("bp_r0_after", req_ready, 2'b01);
    do_reset();

    // Randomized traffic against a transaction-level model.
    pend = '{0, 0};
    m_busy = 0; m_owner = 0; m_pref = 0; m_age = 0; m_res = '0;
    last_res = '0; last_zero = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(2) == 0) begin
            pend[i] = 1;
            p_op[i]  = int'($urandom_range(15));
            p_sel[i] = int'($urandom_range(1));
            p_a[i] = int'($urandom_range(255)); p_b[i] = int'($urandom_range(255));
            p_c[i] = int'($urandom_range(255)); p_d[i] = int'($urandom_range(255));
          end
        end else if ($urandom_range(9) == 0) begin
          pend[i] = 0;
        end
        set_req(i, p_op[i], p_sel[i], p_a[i], p_b[i], p_c[i], p_d[i]);
        req_valid[i] = pend[i];
      end
      rsp_ready = 2'($urandom_range(3));
      #1;
      if (!m_busy) begin
        if (req_valid == 2'b11) exp_ready = m_pref ? 2'b10 : 2'b01;
        else                    exp_ready = req_valid;
        check("rnd_idle", {req_ready, rsp_valid, busy, rsp_zero, rsp_result},
              {exp_ready, 2'b00, 1'b0, last_zero, last_res});
        if (exp_ready != 2'b00) begin
          m_busy  = 1;
          m_owner = exp_ready[1];
          m_res   = ref_alu(p_op[m_owner], p_sel[m_owner], p_a[m_owner],
                            p_b[m_owner], p_c[m_owner], p_d[m_owner]);
          m_age   = 0;
        end
      end else begin
        m_age++;
        if (m_age == 1) begin
          check("rnd_exec", {req_ready, rsp_valid, busy, rsp_zero, rsp_result},
                {2'b00, 2'b00, 1'b1, last_zero, last_res});
        end else begin
          last_res  = m_res;
          last_zero = (m_res == '0);
          check("rnd_resp", {req_ready, rsp_valid, busy, rsp_zero, rsp_result},
                {2'b00, 2'b01 << m_owner, 1'b1, last_zero, last_res});
          if (rsp_ready[m_owner]) begin
            m_busy = 0;
            m_pref = ~m_owner;
          end
        end
      end
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && req_ready[i]) pend[i] = 0;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
